shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the 1-bit shifter unit to perform an
//  N-position shift or rotate on an 8-bit operand. It accepts one request via a
//  valid/ready handshake and steps a shifter instance once per clock. It then
//  holds the result under a valid/ready handshake. It sits between the ALU
//  operation decoder and the ALU result mux.
// PARAMETERS
//  AMT_W      4  width of shift amount; amounts 0..2^AMT_W-1 are accepted
//  FAST_ZERO  1  1: logical shift with amount>=8 skips iteration (result 0x00)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      synchronous reset, active-high
//  start_valid  in   1      request present
//  start_ready  out  1      sequencer can accept request (IDLE only)
//  A            in   8      operand, sampled on accept
//  shifter_Sel  in   2      00 SRL, 01 SLL, 10 ROR, 11 ROL; sampled on accept
//  amount       in   AMT_W  number of 1-bit steps, sampled on accept
//  abort        in   1      drop current operation, return to IDLE
//  res_valid    out  1      result available (DONE only)
//  res_ready    in   1      consumer takes result
//  result       out  8      shifted/rotated value, valid while res_valid
//  busy         out  1      high in SHIFT or DONE
// BEHAVIOUR
//  - Reset: state=IDLE, data_reg=0, cnt=0, op_reg=0; start_ready=1,
//    res_valid=0, result=0x00, busy=0. rst has priority over all inputs.
//  - Accept = start_valid & start_ready. Inputs are ignored when not accepted.
//  - Effective count n computed at accept:
//    rotates (1x): n = amount mod 8;
//    shifts (0x): n = amount if amount<8; if amount>=8: FAST_ZERO=1 -> n=0
//    and data_reg loaded 0x00, FAST_ZERO=0 -> n=amount (iterates to 0x00).
//  - FSM: IDLE --accept, n==0--> DONE (data_reg=A or 0x00 per above)
//         IDLE --accept, n>0 --> SHIFT (data_reg=A, cnt=n, op_reg=sel)
//         SHIFT: each cycle data_reg<=shifter(data_reg,op_reg), cnt<=cnt-1;
//                cnt==1 -> DONE
//         DONE  --res_ready--> IDLE
//         SHIFT/DONE --abort--> IDLE (no result; data_reg cleared)
//  - One internal shifter instance: input data_reg, select op_reg; its output
//    is used only in SHIFT.
//  - Latency: accept at edge T -> res_valid=1 after edge T+1+n (n cycles in
//    SHIFT plus the DONE entry); amount 0 -> res_valid after edge T+1.
//  - result = data_reg when res_valid=1, else 0x00. result and res_valid are
//    held stable while res_ready=0 (no drop, no change).
//  - No back-to-back overlap: start_ready=0 in DONE even if res_ready=1; the
//    next accept occurs earliest the cycle after result handoff.
//  - abort in IDLE: no effect; accept in the same cycle is still taken.
//  - abort with res_ready in DONE: abort wins, handshake not counted.
//  - Rotate wrap: ROR/ROL by 8 -> n=0, result = A unchanged.
//  - Reset asserted mid-SHIFT/DONE: immediate return to reset values, no result.
// TESTING
//  1 A=0xB4, SRL, amount=3 -> res_valid 4 edges after accept, result=0x16.
//  2 A=0x81, ROL, amount=1 -> result=0x03 after 2 edges; busy high 2 cycles.
//  3 A=0x96, ROR, amount=10 (n=2) -> result=0xA5 after 3 edges.
//  4 A=0xFF, SLL, amount=9, FAST_ZERO=1 -> result=0x00, res_valid after 1 edge;
//    same with FAST_ZERO=0 -> result=0x00 after 10 edges.
//  5 A=0x5A, ROL, amount=0, res_ready low 5 cycles -> result=0x5A held stable,
//    start_ready=0 throughout; res_ready high -> IDLE next edge.
//  6 A=0xF0, SRL, amount=7; abort at 3rd SHIFT cycle -> IDLE, res_valid never
//    set; repeat with rst instead -> all outputs at reset values next edge.

Source files
------------

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_unit_1b / shift_sequencer
// Description : Multi-cycle N-position shift/rotate controller stepping a
//               single 1-bit shifter once per clock, valid/ready on both ends.
// Revision    : 1.0 - initial release
// ============================================================================

module shift_unit_1b (
    input  logic [7:0] i_data,
    input  logic [1:0] i_sel,
    output logic [7:0] o_data
);
    always_comb begin
        o_data = i_data;
        case (i_sel)
            2'b00:   o_data = {1'b0, i_data[7:1]};
            2'b01:   o_data = {i_data[6:0], 1'b0};
            2'b10:   o_data = {i_data[0], i_data[7:1]};
            default: o_data = {i_data[6:0], i_data[7]};
        endcase
    end
endmodule

module shift_sequencer #(
    parameter int AMT_W     = 4,
    parameter int FAST_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [7:0]       A,
    input  logic [1:0]       shifter_Sel,
    input  logic [AMT_W-1:0] amount,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       result,
    output logic             busy
);
    localparam int c_CW = (AMT_W > 3) ? AMT_W : 3;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]      r_state;
    logic [7:0]      r_data;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_op;
    logic            r_start_ready;
    logic            r_res_valid;
    logic            r_busy;
    logic [7:0]      r_result;

    logic [c_CW-1:0] w_amt;
    logic [c_CW-1:0] w_n;
    logic            w_big;
    logic            w_zero_load;
    logic [7:0]      w_load;
    logic [7:0]      w_shift;

    shift_unit_1b u_shifter (
        .i_data (r_data),
        .i_sel  (r_op),
        .o_data (w_shift)
    );

    // Effective step count: rotates wrap mod 8, over-long logical shifts may
    // short-circuit straight to a zero result.
    always_comb begin
        w_amt       = c_CW'(amount);
        w_big       = (32'(w_amt) >= 32'd8);
        w_zero_load = !shifter_Sel[1] && w_big && (FAST_ZERO != 0);
        w_load      = w_zero_load ? 8'h00 : A;
        if (shifter_Sel[1]) begin
            w_n = c_CW'(w_amt[2:0]);
        end else if (w_zero_load) begin
            w_n = '0;
        end else begin
            w_n = w_amt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_data        <= 8'h00;
            r_cnt         <= '0;
            r_op          <= 2'b00;
            r_start_ready <= 1'b1;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_result      <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_valid) begin
                        r_op          <= shifter_Sel;
                        r_cnt         <= w_n;
                        r_data        <= w_load;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        if (w_n == '0) begin
                            r_state     <= c_DONE;
                            r_res_valid <= 1'b1;
                            r_result    <= w_load;
                        end else begin
                            r_state     <= c_SHIFT;
                        end
                    end
                end
                c_SHIFT: begin
                    if (abort) begin
                        r_state       <= c_IDLE;
                        r_data        <= 8'h00;
                        r_cnt         <= '0;
                        r_start_ready <= 1'b1;
                        r_busy        <= 1'b0;
                    end else begin
                        r_data <= w_shift;
                        r_cnt  <= r_cnt - c_CW'(1);
                        if (r_cnt == c_CW'(1)) begin
                            r_state     <= c_DONE;
                            r_res_valid <= 1'b1;
                            r_result    <= w_shift;
                        end
                    end
                end
                c_DONE: begin
                    // abort takes precedence over a simultaneous handoff
                    if (abort || res_ready) begin
                        r_state       <= c_IDLE;
                        r_start_ready <= 1'b1;
                        r_res_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_result      <= 8'h00;
                        if (abort) begin
                            r_data <= 8'h00;
                        end
                    end
                end
                default: begin
                    r_state       <= c_IDLE;
                    r_data        <= 8'h00;
                    r_cnt         <= '0;
                    r_start_ready <= 1'b1;
                    r_res_valid   <= 1'b0;
                    r_busy        <= 1'b0;
                    r_result      <= 8'h00;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign res_valid   = r_res_valid;
    assign busy        = r_busy;
    assign result      = r_result;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Randomized self-checking bench; dut index 0 has FAST_ZERO=1,
//               index 1 has FAST_ZERO=0, both compared to an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_valid;
    logic [1:0] start_ready;
    logic [7:0] A;
    logic [1:0] sel;
    logic [3:0] amount;
    logic       abort;
    logic [1:0] res_valid;
    logic       res_ready;
    logic [7:0] result [2];
    logic [1:0] busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.AMT_W(4), .FAST_ZERO(1)) u_dut_fz (
        .clk(clk), .rst(rst), .start_valid(start_valid[0]), .start_ready(start_ready[0]),
        .A(A), .shifter_Sel(sel), .amount(amount), .abort(abort),
        .res_valid(res_valid[0]), .res_ready(res_ready), .result(result[0]), .busy(busy[0])
    );

    shift_sequencer #(.AMT_W(4), .FAST_ZERO(0)) u_dut_it (
        .clk(clk), .rst(rst), .start_valid(start_valid[1]), .start_ready(start_ready[1]),
        .A(A), .shifter_Sel(sel), .amount(amount), .abort(abort),
        .res_valid(res_valid[1]), .res_ready(res_ready), .result(result[1]), .busy(busy[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: result from plain arithmetic, latency = edges from accept to res_valid
    task automatic model(input int d, input logic [7:0] a, input logic [1:0] s,
                         input logic [3:0] amt, output logic [7:0] res, output int lat);
        int av, k;
        av = int'(a);
        if (s[1]) begin
            k = int'(amt) % 8;
            if (s[0]) res = 8'(((av << k) | (av >> (8 - k))) & 255);
            else      res = 8'(((av >> k) | (av << (8 - k))) & 255);
            lat = k + 1;
        end else begin
            if (amt >= 4'd8)  res = 8'h00;
            else if (s[0])    res = 8'((av << amt) & 255);
            else              res = 8'(av >> amt);
            lat = (amt >= 4'd8 && d == 0) ? 1 : int'(amt) + 1;
        end
    endtask

    task automatic run_op(input int d, input logic [7:0] a, input logic [1:0] s,
                          input logic [3:0] amt, input int hold, input bit ab_acc);
        logic [7:0] exp_res;
        int         exp_lat;
        int         edges;
        bit         ok;
        model(d, a, s, amt, exp_res, exp_lat);
        @(negedge clk);
        check_eq("start_ready_idle", 32'(start_ready[d]), 32'd1);
        A = a; sel = s; amount = amt; abort = ab_acc; res_ready = 1'b0;
        start_valid[d] = 1'b1;
        @(negedge clk);
        start_valid = 2'b00; abort = 1'b0;
        edges = 1; ok = 1'b1;
        while (!res_valid[d] && edges < 40) begin
            if (result[d] !== 8'h00 || busy[d] !== 1'b1 || start_ready[d] !== 1'b0) ok = 1'b0;
            @(negedge clk);
            edges++;
        end
        check_eq("latency", 32'(edges), 32'(exp_lat));
        check_eq("result", 32'(result[d]), 32'(exp_res));
        check_eq("busy_while_shifting", 32'(ok), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_valid[d] !== 1'b1 || result[d] !== exp_res ||
                start_ready[d] !== 1'b0 || busy[d] !== 1'b1) ok = 1'b0;
        end
        if (hold > 0) check_eq("hold_stable", 32'(ok), 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("after_handoff", {29'd0, res_valid[d], start_ready[d], busy[d]}, 32'b010);
        check_eq("result_cleared", 32'(result[d]), 32'd0);
    endtask

    // Accept an SRL by 7 and interrupt it on the 3rd SHIFT cycle by abort or rst
    task automatic interrupt_op(input bit use_rst);
        bit ok;
        @(negedge clk);
        A = 8'hF0; sel = 2'b00; amount = 4'd7; start_valid[0] = 1'b1;
        @(negedge clk);
        start_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        if (use_rst) rst = 1'b1; else abort = 1'b1;
        @(negedge clk);
        rst = 1'b0; abort = 1'b0;
        check_eq(use_rst ? "rst_outputs" : "abort_outputs",
                 {20'd0, start_ready[0], res_valid[0], busy[0], result[0], 1'b0}, {20'd0, 3'b100, 8'h00, 1'b0});
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid[0] !== 1'b0 || busy[0] !== 1'b0) ok = 1'b0;
        end
        check_eq(use_rst ? "rst_no_result" : "abort_no_result", 32'(ok), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start_valid = 2'b00; A = 8'h00; sel = 2'b00; amount = 4'd0;
        abort = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_state", {16'd0, start_ready, res_valid, busy, result[0]},
                 {16'd0, 2'b11, 2'b00, 2'b00, 8'h00});
        rst = 1'b0;

        run_op(0, 8'hB4, 2'b00, 4'd3, 0, 1'b0);
        run_op(0, 8'h81, 2'b11, 4'd1, 0, 1'b0);
        run_op(0, 8'h96, 2'b10, 4'd10, 1, 1'b0);
        run_op(0, 8'hFF, 2'b01, 4'd9, 0, 1'b0);
        run_op(1, 8'hFF, 2'b01, 4'd9, 0, 1'b0);
        run_op(0, 8'h5A, 2'b11, 4'd0, 5, 1'b0);
        run_op(1, 8'hC3, 2'b10, 4'd8, 2, 1'b0);
        run_op(0, 8'h12, 2'b01, 4'd2, 0, 1'b1);

        interrupt_op(1'b0);
        interrupt_op(1'b1);

        // abort together with res_ready in DONE: result dropped, back to IDLE
        @(negedge clk);
        A = 8'h3C; sel = 2'b11; amount = 4'd0; start_valid[0] = 1'b1;
        @(negedge clk);
        start_valid = 2'b00;
        check_eq("done_entry", 32'(res_valid[0]), 32'd1);
        abort = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; res_ready = 1'b0;
        check_eq("abort_in_done", {30'd0, res_valid[0], start_ready[0]}, 32'b01);

        for (int t = 0; t < 60; t++) begin
            run_op(int'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                   4'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
